dac_sample_pwm: RTL and testbench

DAC_SAMPLE_PWM -- requirements
Module: dac_sample_pwm

---
 rtl/dac_sample_pwm.sv | 128 ++++++++++++
 tb/tb_dac_sample_pwm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_pwm.sv
// Sample FIFO feeding a 512-slot PWM audio DAC.
// PCM samples are buffered, popped once per frame, converted to offset-binary duty and compared against phase.
module dac_sample_pwm #(
  parameter int         DEPTH    = 16,
  parameter logic [8:0] MID_DUTY = 9'd256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     dac_clk,
  input  logic                     next_sample,
  input  logic [8:0]               phase,
  input  logic                     mute,
  input  logic                     underrun_clr,
  output logic                     underrun,
  output logic                     pwm_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [1:0]    rstSync_q;
  logic          opReady;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic [8:0]    duty_q, duty_d;
  logic          pwm_q, pwm_d;
  logic          underrun_q, underrun_d;
  logic          levelZero;
  logic          wrAcc;
  logic          popAcc;
  logic [8:0]    popConv;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign opReady   = rstSync_q[1];
  assign levelZero = (level_q == '0);
  assign popAcc    = opReady && next_sample && !levelZero;
  // A pop frees a slot in the same cycle, so a write is accepted even while full.
  assign wrAcc     = opReady && wr_en && (!full_q || popAcc);
  assign popConv   = {~mem_q[rdPtr_q][15], mem_q[rdPtr_q][14:7]};

  always_ff @(posedge clk) begin
    if (wrAcc) begin
      mem_q[wrPtr_q] <= wr_data;
    end
  end

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    level_d    = level_q;
    duty_d     = duty_q;
    pwm_d      = pwm_q;
    underrun_d = underrun_q;

    if (wrAcc) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (popAcc) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    case ({wrAcc, popAcc})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (opReady && dac_clk) begin
      pwm_d = (phase < duty_q);
    end

    if (opReady && next_sample) begin
      if (mute || levelZero) begin
        duty_d = MID_DUTY;
      end else begin
        duty_d = popConv;
      end
    end

    if (opReady && next_sample && levelZero) begin
      underrun_d = 1'b1;
    end else if (opReady && underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  assign full_d = (level_d == LW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      duty_q     <= MID_DUTY;
      pwm_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
      underrun_q <= underrun_d;
    end
  end

  assign full     = full_q;
  assign level    = level_q;
  assign underrun = underrun_q;
  assign pwm_out  = pwm_q;

endmodule

// File: tb/tb_dac_sample_pwm.sv
// Directed bench for dac_sample_pwm: flag checks inline, per-frame PWM high counts via a scoreboard queue.
// The monitor counts pwm_out slots per frame and compares against the queued expectation.
module tb_dac_sample_pwm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        full;
  logic [4:0]  level;
  logic        dac_clk;
  logic        next_sample;
  logic [8:0]  phase;
  logic        mute;
  logic        underrun_clr;
  logic        underrun;
  logic        pwm_out;

  int checks = 0;
  int errors = 0;
  int expQ[$];

  dac_sample_pwm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .full         (full),
    .level        (level),
    .dac_clk      (dac_clk),
    .next_sample  (next_sample),
    .phase        (phase),
    .mute         (mute),
    .underrun_clr (underrun_clr),
    .underrun     (underrun),
    .pwm_out      (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic dac, input logic [8:0] ph, input logic ns,
                               input logic we, input logic [15:0] data, input logic clr);
    @(negedge clk);
    dac_clk      = dac;
    phase        = ph;
    next_sample  = ns;
    wr_en        = we;
    wr_data      = data;
    underrun_clr = clr;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, phase, 1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic writeSample(input logic [15:0] data);
    applyStimulus(1'b0, phase, 1'b0, 1'b1, data, 1'b0);
    idleCycle();
  endtask

  task automatic runFrames(input int n);
    for (int f = 0; f < n; f++) begin
      for (int p = 0; p < 512; p++) begin
        applyStimulus(1'b1, 9'(p), (p == 511), 1'b0, 16'h0000, 1'b0);
      end
    end
    idleCycle();
  endtask

  // Slot monitor: sample the slot inputs at the edge, read the registered bit just after it.
  int  highCnt = 0;
  bit  inFrame = 1'b0;
  bit  sawLow  = 1'b0;
  bit  gap     = 1'b0;
  always @(posedge clk) begin
    logic       sDac;
    logic [8:0] sPh;
    int         expCnt;
    sDac = dac_clk;
    sPh  = phase;
    #1;
    if (rst_n !== 1'b1) begin
      inFrame = 1'b0;
    end else if (sDac === 1'b1) begin
      if (sPh == 9'd0) begin
        inFrame = 1'b1;
        highCnt = 0;
        sawLow  = 1'b0;
        gap     = 1'b0;
      end
      if (inFrame) begin
        if (pwm_out === 1'b1) begin
          highCnt++;
          if (sawLow) gap = 1'b1;
        end else begin
          sawLow = 1'b1;
        end
        if (sPh == 9'd511) begin
          inFrame = 1'b0;
          checks++;
          if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL frameUnexpected: got %0d high slots, expected no frame", highCnt);
          end else begin
            expCnt = expQ.pop_front();
            if (highCnt != expCnt || gap) begin
              errors++;
              $display("[TB] FAIL frameHigh: got %0d high slots (gap=%0d), expected %0d contiguous",
                       highCnt, gap, expCnt);
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b1;
    wr_data      = 16'h0000;
    wr_en        = 1'b0;
    dac_clk      = 1'b0;
    next_sample  = 1'b0;
    phase        = 9'd0;
    mute         = 1'b0;
    underrun_clr = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstLevel", int'(level), 0);
    checkOutput("rstFull", int'(full), 0);
    checkOutput("rstUnderrun", int'(underrun), 0);
    checkOutput("rstPwm", int'(pwm_out), 0);
    rst_n = 1'b1;
    repeat (4) idleCycle();

    // Fill with 17 samples k*128 (conv = 256+k); the 17th must be dropped.
    for (int k = 1; k <= 17; k++) writeSample(16'(k * 128));
    checkOutput("fillLevel", int'(level), 16);
    checkOutput("fillFull", int'(full), 1);
    expQ.push_back(256);
    for (int k = 1; k <= 16; k++) expQ.push_back(256 + k);
    runFrames(1);
    checkOutput("popLevel", int'(level), 15);
    checkOutput("popFull", int'(full), 0);
    runFrames(15);
    checkOutput("drainLevel", int'(level), 0);
    checkOutput("drainUnderrun", int'(underrun), 0);
    runFrames(1);
    checkOutput("emptyUnderrun", int'(underrun), 1);

    // Underrun: duty falls back to mid, flag is sticky, clear works, set beats clear.
    expQ.push_back(256);
    runFrames(1);
    checkOutput("stickyUnderrun", int'(underrun), 1);
    applyStimulus(1'b0, phase, 1'b0, 1'b0, 16'h0000, 1'b1);
    idleCycle();
    checkOutput("clrUnderrun", int'(underrun), 0);
    applyStimulus(1'b0, phase, 1'b1, 1'b0, 16'h0000, 1'b1);
    idleCycle();
    checkOutput("setWinsUnderrun", int'(underrun), 1);

    // Conversion extremes through full frames.
    applyStimulus(1'b0, phase, 1'b0, 1'b0, 16'h0000, 1'b1);
    idleCycle();
    writeSample(16'h8000);
    writeSample(16'h0000);
    writeSample(16'h7FFF);
    checkOutput("convLevel", int'(level), 3);
    expQ.push_back(256);
    expQ.push_back(0);
    expQ.push_back(256);
    expQ.push_back(511);
    runFrames(4);
    checkOutput("convDrainLevel", int'(level), 0);
    checkOutput("convUnderrun", int'(underrun), 1);

    // Write coinciding with an empty pop must not bypass.
    applyStimulus(1'b0, phase, 1'b0, 1'b0, 16'h0000, 1'b1);
    idleCycle();
    checkOutput("clrUnderrun2", int'(underrun), 0);
    applyStimulus(1'b0, phase, 1'b1, 1'b1, 16'hC000, 1'b0);
    idleCycle();
    checkOutput("wrEmptyUnderrun", int'(underrun), 1);
    checkOutput("wrEmptyLevel", int'(level), 1);
    expQ.push_back(256);
    expQ.push_back(128);
    runFrames(2);
    checkOutput("wrEmptyDrain", int'(level), 0);

    // Mute drains the FIFO in real time while holding mid duty.
    applyStimulus(1'b0, phase, 1'b0, 1'b0, 16'h0000, 1'b1);
    idleCycle();
    checkOutput("clrUnderrun3", int'(underrun), 0);
    for (int k = 0; k < 4; k++) writeSample(16'h7FFF);
    checkOutput("muteLevel", int'(level), 4);
    mute = 1'b1;
    for (int k = 0; k < 4; k++) expQ.push_back(256);
    runFrames(4);
    mute = 1'b0;
    checkOutput("muteDrain", int'(level), 0);
    checkOutput("muteUnderrun", int'(underrun), 0);

    // Asynchronous reset in the middle of a frame.
    for (int k = 0; k < 8; k++) writeSample(16'h7FFF);
    checkOutput("preRstLevel", int'(level), 8);
    for (int p = 0; p < 10; p++) applyStimulus(1'b1, 9'(p), 1'b0, 1'b0, 16'h0000, 1'b0);
    idleCycle();
    checkOutput("preRstPwm", int'(pwm_out), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncRstPwm", int'(pwm_out), 0);
    checkOutput("asyncRstLevel", int'(level), 0);
    checkOutput("asyncRstFull", int'(full), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) idleCycle();
    checkOutput("postRstUnderrunClear", int'(underrun), 0);
    applyStimulus(1'b0, phase, 1'b1, 1'b0, 16'h0000, 1'b0);
    idleCycle();
    checkOutput("postRstUnderrun", int'(underrun), 1);
    checkOutput("postRstLevel", int'(level), 0);

    repeat (2) idleCycle();
    checkOutput("framesPending", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
